calc_seq_core: RTL and testbench

Parametrised keypad calculator core: accepts a stream of decoded key codes, assembles two signed decimal operands and one operator, then produces a signed two's-complement result or an error flag. Successor to the fixed 3-digit operator block, with these additions:
- configurable digit count and result width;
- a key strobe in place of a level select;
- a clear key;
- a proper start/done handshake to a sequential multiplier;
- an explicit busy/valid output handshake.

Sits between the keyboard scan-code decoder and the display driver.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_seq_core_seq_mult.sv | 60 ++++++
 rtl/calc_seq_core.sv | 216 +++++++++++++++++++++
 tb/tb_calc_seq_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator core.
//   - key code constants from the scan-code decoder
//   - operator enum and FSM state encodings
//   - calc_maxv(): largest magnitude representable with a given digit count
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_CLR   = 4'd13;
  localparam logic [3:0] KEY_ENT   = 4'd14;

  typedef enum logic [1:0] {
    OpAdd,
    OpSub,
    OpMul
  } op_e;

  // FSM state encodings, kept as plain constants for legacy tooling.
  localparam logic [2:0] StSign1 = 3'd0;
  localparam logic [2:0] StOp1   = 3'd1;
  localparam logic [2:0] StOper  = 3'd2;
  localparam logic [2:0] StSign2 = 3'd3;
  localparam logic [2:0] StOp2   = 3'd4;
  localparam logic [2:0] StExec  = 3'd5;
  localparam logic [2:0] StMul   = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  // 10^digits - 1
  function automatic int unsigned calc_maxv(int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/calc_seq_core_seq_mult.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands a/b and begin
//   abort         drop any operation in flight (no done)
//   a, b          N-bit unsigned operands
//   prod          2N-bit product, valid while done is high
//   done          single-cycle pulse exactly N cycles after start
module seq_mult #(
  parameter int unsigned N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod,
  output logic           done
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CntW-1:0] cnt_q;
  logic           run_q;

  // Bit 0 is consumed on the start edge so the remaining N-1 bits finish
  // in time for done to land exactly N cycles after start.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? (2*N)'(a) : '0;
      mcand_q  <= (2*N)'(a) << 1;
      mplier_q <= b >> 1;
      cnt_q    <= CntW'(N - 1);
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
      end
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign prod = acc_q;

endmodule

// File: rtl/calc_seq_core.sv
// Keypad calculator core: assembles two signed decimal operands and an
// operator from a key strobe stream and produces a signed result.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0-9 digit, 10 +, 11 -, 12 x, 13 clear, 14 enter
//   result         signed W-bit result, held until next result/clear/rst
//   result_valid   one-cycle pulse when result/err update
//   busy           high while evaluating (EXEC or MUL)
//   err            sticky overflow flag, cleared by clear/rst
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         busy,
  output logic         err
);

  localparam int unsigned MaxV = calc_maxv(DIGITS);
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0]  DigitsC = CntW'(DIGITS);
  localparam logic [W:0]       MaxVS   = (W+1)'(MaxV);
  localparam logic [2*W-3:0]   MaxVP   = (2*W-2)'(MaxV);

  logic [2:0]      state_q, state_d;
  logic            neg1_q, neg1_d, neg2_q, neg2_d;
  logic [W-2:0]    mag1_q, mag1_d, mag2_q, mag2_d;
  logic [CntW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  op_e             op_q, op_d;
  logic [W-1:0]    result_q, result_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;

  logic            clr, is_digit, is_sign;
  logic [W-2:0]    digit, acc1, acc2;
  logic [W:0]      s1, s2, sum, sum_abs;
  logic [W-1:0]    mul_mag, mul_signed;
  logic            mul_start, mul_done;
  logic [2*W-3:0]  mul_prod;

  assign clr      = key_valid && (key_code == KEY_CLR);
  assign is_digit = key_code <= 4'd9;
  assign is_sign  = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
  assign digit    = (W-1)'(key_code);
  assign acc1     = (W-1)'({4'b0, mag1_q} * (W+3)'(10) + (W+3)'(key_code));
  assign acc2     = (W-1)'({4'b0, mag2_q} * (W+3)'(10) + (W+3)'(key_code));

  // Add/sub in W+1 bits so the worst case (+/-2*MaxV) cannot wrap.
  assign s1      = neg1_q ? -{2'b00, mag1_q} : {2'b00, mag1_q};
  assign s2      = neg2_q ? -{2'b00, mag2_q} : {2'b00, mag2_q};
  assign sum     = (op_q == OpSub) ? s1 - s2 : s1 + s2;
  assign sum_abs = sum[W] ? -sum : sum;

  // A product of zero negates to zero, so no negative-zero special case.
  assign mul_mag    = mul_prod[W-1:0];
  assign mul_signed = (neg1_q ^ neg2_q) ? -mul_mag : mul_mag;

  assign mul_start = (state_q == StExec) && (op_q == OpMul) && !clr;

  seq_mult #(
    .N(W - 1)
  ) u_seq_mult (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .abort(clr),
    .a    (mag1_q),
    .b    (mag2_q),
    .prod (mul_prod),
    .done (mul_done)
  );

  always_comb begin
    state_d  = state_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    rv_d     = 1'b0;

    if (clr) begin
      state_d  = StSign1;
      neg1_d   = 1'b0;
      neg2_d   = 1'b0;
      mag1_d   = '0;
      mag2_d   = '0;
      cnt1_d   = '0;
      cnt2_d   = '0;
      op_d     = OpAdd;
      result_d = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        StSign1: if (key_valid) begin
          if (is_digit) begin
            neg1_d  = 1'b0;
            mag1_d  = digit;
            cnt1_d  = CntW'(1);
            state_d = StOp1;
          end else if (is_sign) begin
            neg1_d  = (key_code == KEY_MINUS);
            state_d = StOp1;
          end
        end
        StOp1: if (key_valid) begin
          if (is_digit) begin
            if (cnt1_q < DigitsC) begin
              mag1_d = acc1;
              cnt1_d = cnt1_q + 1'b1;
            end
          end else if (key_code == KEY_ENT) begin
            state_d = StOper;
          end
        end
        StOper: if (key_valid) begin
          if (key_code == KEY_PLUS) begin
            op_d    = OpAdd;
            state_d = StSign2;
          end else if (key_code == KEY_MINUS) begin
            op_d    = OpSub;
            state_d = StSign2;
          end else if (key_code == KEY_MUL) begin
            op_d    = OpMul;
            state_d = StSign2;
          end
        end
        StSign2: if (key_valid) begin
          if (is_digit) begin
            neg2_d  = 1'b0;
            mag2_d  = digit;
            cnt2_d  = CntW'(1);
            state_d = StOp2;
          end else if (is_sign) begin
            neg2_d  = (key_code == KEY_MINUS);
            state_d = StOp2;
          end
        end
        StOp2: if (key_valid) begin
          if (is_digit) begin
            if (cnt2_q < DigitsC) begin
              mag2_d = acc2;
              cnt2_d = cnt2_q + 1'b1;
            end
          end else if (key_code == KEY_ENT) begin
            state_d = StExec;
          end
        end
        StExec: begin
          if (op_q == OpMul) begin
            state_d = StMul;
          end else begin
            err_d    = sum_abs > MaxVS;
            result_d = (sum_abs > MaxVS) ? '0 : sum[W-1:0];
            rv_d     = 1'b1;
            state_d  = StDone;
          end
        end
        StMul: if (mul_done) begin
          err_d    = mul_prod > MaxVP;
          result_d = (mul_prod > MaxVP) ? '0 : mul_signed;
          rv_d     = 1'b1;
          state_d  = StDone;
        end
        StDone:  ;
        default: state_d = StSign1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StSign1;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      op_q     <= OpAdd;
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      op_q     <= op_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign busy         = (state_q == StExec) || (state_q == StMul);

endmodule

// File: tb/tb_calc_seq_core.sv
// Self-checking bench for calc_seq_core: a key-level behavioural model is
// compared against the DUT outputs every cycle, plus literal expectations for
// the hand-worked sequences.
module tb_calc_seq_core;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned W      = 11;
  localparam int          MAXV   = 999;  // 10^DIGITS - 1

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_seq_core #(
    .DIGITS(DIGITS),
    .W     (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // stage: 0 first sign, 1 first operand, 2 operator, 3 second sign,
  // 4 second operand, 5 evaluating, 6 finished
  int m_stage = 0, m_op = 0, m_cd = 0, p_res = 0, m_res = 0;
  int m_val[2];
  int m_nd[2];
  bit m_neg[2];
  bit p_err = 0, m_err = 0, m_rv = 0, started = 0;

  task automatic m_clear();
    m_stage = 0; m_op = 0; m_cd = 0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_nd[i] = 0; m_neg[i] = 0;
    end
    m_res = 0; m_err = 0; m_rv = 0;
  endtask

  task automatic m_launch();
    int a, b, r;
    a = m_neg[0] ? -m_val[0] : m_val[0];
    b = m_neg[1] ? -m_val[1] : m_val[1];
    r = (m_op == 0) ? a + b : (m_op == 1) ? a - b : a * b;
    p_err = (r > MAXV) || (r < -MAXV);
    p_res = p_err ? 0 : r;
    m_cd  = (m_op == 2) ? int'(W) : 1;
    m_stage = 5;
  endtask

  task automatic m_step(input bit kv, input int k);
    int i;
    m_rv = 0;
    i = (m_stage >= 3) ? 1 : 0;
    if (m_stage == 5) begin
      m_cd--;
      if (m_cd == 0) begin
        m_res = p_res; m_err = p_err; m_rv = 1; m_stage = 6;
      end
    end else if (kv && m_stage < 5) begin
      if (m_stage == 0 || m_stage == 3) begin
        if (k <= 9) begin
          m_neg[i] = 0; m_val[i] = k; m_nd[i] = 1; m_stage++;
        end else if (k == 10 || k == 11) begin
          m_neg[i] = (k == 11); m_stage++;
        end
      end else if (m_stage == 1 || m_stage == 4) begin
        if (k <= 9) begin
          if (m_nd[i] < int'(DIGITS)) begin
            m_val[i] = m_val[i] * 10 + k; m_nd[i]++;
          end
        end else if (k == 14) begin
          if (m_stage == 1) m_stage = 2;
          else m_launch();
        end
      end else if (m_stage == 2) begin
        if (k >= 10 && k <= 12) begin
          m_op = k - 10; m_stage = 3;
        end
      end
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_clear();
        started = 1;
      end else if (key_valid && key_code == 4'd13) begin
        m_clear();
      end else begin
        m_step(key_valid, int'(key_code));
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("cyc_result", $signed(result), m_res);
      chk("cyc_result_valid", {31'b0, result_valid}, {31'b0, m_rv});
      chk("cyc_busy", {31'b0, busy}, (m_stage == 5) ? 1 : 0);
      chk("cyc_err", {31'b0, err}, {31'b0, m_err});
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] key_of(input byte c);
    case (c)
      "+":     return 4'd10;
      "-":     return 4'd11;
      "*":     return 4'd12;
      "C":     return 4'd13;
      "E":     return 4'd14;
      default: return 4'(c - 8'd48);
    endcase
  endfunction

  task automatic run_str(input string s);
    for (int i = 0; i < s.len(); i++) press(key_of(s.getc(i)));
  endtask

  // Called right after the enter press; lat counts cycles from the enter edge.
  task automatic expect_res(input string name, input int res, input bit e,
                            input int lat_exp, input int busy_exp);
    int lat, nbusy;
    lat   = 1;
    nbusy = busy ? 1 : 0;
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    chk({name, "_latency"}, lat, lat_exp);
    chk({name, "_busy_cycles"}, nbusy, busy_exp);
    chk({name, "_result"}, $signed(result), res);
    chk({name, "_err"}, {31'b0, err}, {31'b0, e});
  endtask

  task automatic press_g(input logic [3:0] k);
    press(k);
    if ($urandom_range(0, 5) == 0) press(4'($urandom_range(0, 15)));
    else if ($urandom_range(0, 3) == 0) idle(1);
  endtask

  initial begin
    int nrv;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_result", $signed(result), 0);
    chk("reset_result_valid", {31'b0, result_valid}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_err", {31'b0, err}, 0);

    run_str("+123E++45E");
    expect_res("add", 168, 1'b0, 2, 1);
    idle(1);
    chk("add_single_pulse", {31'b0, result_valid}, 0);

    run_str("C-999E-+999E");
    expect_res("sub_ovf", 0, 1'b1, 2, 1);

    run_str("C12E*-11E");
    expect_res("mul_neg", -132, 1'b0, 12, 11);

    run_str("C100E*10E");
    expect_res("mul_ovf", 0, 1'b1, 12, 11);
    press(4'd13);
    chk("clear_err", {31'b0, err}, 0);
    chk("clear_result", $signed(result), 0);

    run_str("C-0E*5E");
    expect_res("neg_zero_mul", 0, 1'b0, 12, 11);
    run_str("C-5E+5E");
    expect_res("zero_sum", 0, 1'b0, 2, 1);

    run_str("C1234E+1E");
    expect_res("digit_limit", 124, 1'b0, 2, 1);

    run_str("C1234E*2E");
    idle(4);
    chk("abort_busy_before", {31'b0, busy}, 1);
    press(4'd13);
    chk("abort_busy_after", {31'b0, busy}, 0);
    nrv = 0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) nrv++;
      @(negedge clk);
    end
    chk("abort_no_result_valid", nrv, 0);

    run_str("C7E+5");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_result", $signed(result), 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_err", {31'b0, err}, 0);
    run_str("7E-2E");
    expect_res("after_rst", 5, 1'b0, 2, 1);

    // Randomised sequences; the per-cycle compare tracks them all.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      press(4'd13);
      for (int o = 0; o < 2; o++) begin
        if ($urandom_range(0, 1) == 1) press_g(4'(10 + $urandom_range(0, 1)));
        for (int d = 0; d < int'($urandom_range(0, 4)); d++)
          press_g(4'($urandom_range(0, 9)));
        press_g(4'd14);
        if (o == 0) press_g(4'(10 + $urandom_range(0, 2)));
      end
      idle($urandom_range(0, 14));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
